mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- MEM-stage controller between the EX/MEM pipeline register and the data-memory port.
- Accepts one load or store per request and checks alignment.
- Generates byte enables and replicated write data, then runs a req/ack handshake with multi-cycle memory.
- Stalls the pipeline while the access is outstanding.
- Delivers the raw read word, load type and low address bits to the downstream load-extract (byte/halfword split) stage.

Parameters:
- ADDR_W, 32, byte-address width.
- MAX_WAIT, 15, maximum cycles in REQ without mem_ack before a bus error. Legal range 1..255.

Ports:
- clk  in  1  pipeline clock.
- rst_n  in  1  reset; synchronous, active-low.
- ex_valid  in  1  request present from EX/MEM.
- ex_mem_read  in  1  request is a load.
- ex_mem_write  in  1  request is a store.
- ex_addr  in  ADDR_W  byte address.
- ex_load_type  in  3  LB=0, LBU=1, LH=2, LHU=3, LW=4.
- ex_store_type  in  2  SB=0, SH=1, SW=2.
- ex_store_data  in  32  store data, right-justified.
- stall  out  1  freezes upstream stages.
- mem_req  out  1  memory request.
- mem_we  out  1  1 = write.
- mem_addr  out  ADDR_W  word-aligned address (addr[1:0] forced to 0).
- mem_be  out  4  byte enables; bit i = byte lane i = data[8i+7:8i].
- mem_wdata  out  32  lane-replicated write data.
- mem_ack  in  1  memory completes the current request in this cycle.
- mem_rdata  in  32  read word; valid when mem_ack=1.
- ld_valid  out  1  one-cycle pulse: ld_* outputs valid.
- ld_data  out  32  raw memory word.
- ld_type  out  3  latched load type.
- ld_addr_lo  out  2  latched ex_addr[1:0].
- exc_align  out  1  one-cycle misalignment pulse.
- exc_bus  out  1  one-cycle bus-timeout pulse.

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE, wait counter=0, all outputs 0. Takes effect even mid-transaction: mem_req drops at that edge and no ld_valid or exception pulse is produced for the aborted access.
- States: IDLE and REQ.
- Accept condition, evaluated in IDLE: ex_valid & (ex_mem_read | ex_mem_write).
  - Read and write both set: the read is performed and the write is suppressed.
  - ex_valid while in REQ is ignored; upstream is stalled during REQ.
- Misaligned requests:
  - Halfword accesses (LH, LHU, SH) with addr[0]=1.
  - Word accesses (LW, SW) with addr[1:0]!=0.
  - Result: no memory access, no stall, exc_align=1 on the following cycle, state stays IDLE.
  - Illegal type codes (load type >4, store type 3) are treated as misaligned.
- Aligned accept, IDLE->REQ:
  - stall=1 combinationally in the accept cycle.
  - At the edge, latch mem_we, mem_addr, mem_be, mem_wdata, ld_type and ld_addr_lo; set mem_req=1; clear the counter.
- REQ:
  - mem_req and all mem_* outputs are held stable until completion.
  - stall = ~mem_ack, so upstream advances in the ack cycle.
  - The counter increments each cycle without ack.
- mem_ack in REQ: next edge goes to IDLE with mem_req=0.
  - Load: ld_data<=mem_rdata and ld_valid=1 for exactly one cycle (one cycle after ack).
  - Store: no ld_valid.
  - A new request presented in that following cycle is accepted (back-to-back; 1 idle cycle between mem_req pulses minimum).
- Timeout: counter==MAX_WAIT with no ack in REQ -> next edge goes to IDLE, mem_req=0, exc_bus pulses 1 cycle, stall released. An ack arriving in the same cycle as the limit wins and there is no exception.
- mem_ack seen in IDLE is ignored.
- Store lane generation:
  - SB: be = 4'b0001 << addr[1:0]; wdata = {4{d[7:0]}}.
  - SH: be = addr[1] ? 4'b1100 : 4'b0011; wdata = {2{d[15:0]}}.
  - SW: be = 4'b1111; wdata = d.
- Loads drive be=4'b1111 and wdata=0.
- ld_data, ld_type and ld_addr_lo hold their values between pulses.

Decomposition:
- Shared package mem_pkg:
  - Load-type codes LOAD_LB..LOAD_LW (0..4), shared with the load-extract stage.
  - Store-type codes STORE_SB/SH/SW.
  - State encoding IDLE/REQ.
- One combinational sub-module, mem_byte_lane_gen:
  - Inputs: addr[1:0], store type, load type, read/write, store data.
  - Outputs: be, wdata, misaligned.
  - Instantiated once in mem_access_unit.

Test Plan:
- SB addr=0x1003, data=0x000000A5, ack after 2 cycles -> mem_addr=0x1000, be=4'b1000, wdata=0xA5A5A5A5, stall high 3 cycles, no ld_valid.
- LH addr=0x2002, rdata=0x8001_7FFF, ack after 1 cycle -> ld_valid pulse one cycle after ack, ld_data=0x80017FFF, ld_type=2, ld_addr_lo=2'b10.
- LW addr=0x3001 -> no mem_req, stall never asserted, exc_align=1 for one cycle.
- LW with no ack for MAX_WAIT=15 cycles -> mem_req drops, exc_bus one pulse, stall released, next LW accepted normally.
- Back-to-back SW then LW, each acked immediately -> both issue with one idle cycle between mem_req pulses; LW gets ld_valid only.
- rst_n=0 during REQ of an LBU -> mem_req=0 and all outputs 0 at that edge; no ld_valid or exceptions; a late mem_ack afterwards is ignored.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the MEM stage: load/store type codes (also used by
// the downstream load-extract stage) and the access FSM state encoding.
package mem_pkg;

    // Load type codes as presented on ex_load_type and returned on ld_type.
    localparam logic [2:0] LOAD_LB  = 3'd0;
    localparam logic [2:0] LOAD_LBU = 3'd1;
    localparam logic [2:0] LOAD_LH  = 3'd2;
    localparam logic [2:0] LOAD_LHU = 3'd3;
    localparam logic [2:0] LOAD_LW  = 3'd4;

    // Store type codes; code 3 is unused and treated as an illegal access.
    localparam logic [1:0] STORE_SB = 2'd0;
    localparam logic [1:0] STORE_SH = 2'd1;
    localparam logic [1:0] STORE_SW = 2'd2;

    // Access FSM states.
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_REQ  = 1'b1;

endpackage

// File: rtl/mem_access_unit_if.sv
// Data-memory port: req/ack handshake plus address, byte enables and data.
// The MEM stage is the master; the memory (or bench model) is the slave.
interface mem_access_unit_if #(
    parameter int ADDR_W = 32
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [3:0]        mem_be;
    logic [31:0]       mem_wdata;
    logic              mem_ack;
    logic [31:0]       mem_rdata;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_be,
        output mem_wdata,
        input  mem_ack,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_be,
        input  mem_wdata,
        output mem_ack,
        output mem_rdata
    );
endinterface

// File: rtl/mem_byte_lane_gen.sv
// Combinational byte-lane generator: byte enables, lane-replicated write data
// and the misalignment flag for one load or store request.
module mem_byte_lane_gen
    import mem_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  store_type,
    input  logic [2:0]  load_type,
    input  logic        is_read,
    input  logic [31:0] store_data,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic        misaligned
);

    // Decode access size into lanes; illegal type codes report as misaligned.
    always_comb begin
        be         = 4'b0000;
        wdata      = 32'h0000_0000;
        misaligned = 1'b0;
        if (is_read) begin
            be    = 4'b1111;
            wdata = 32'h0000_0000;
            case (load_type)
                LOAD_LB, LOAD_LBU: misaligned = 1'b0;
                LOAD_LH, LOAD_LHU: misaligned = addr_lo[0];
                LOAD_LW:           misaligned = (addr_lo != 2'b00);
                default:           misaligned = 1'b1;
            endcase
        end else begin
            case (store_type)
                STORE_SB: begin
                    be         = 4'b0001 << addr_lo;
                    wdata      = {4{store_data[7:0]}};
                    misaligned = 1'b0;
                end
                STORE_SH: begin
                    be         = addr_lo[1] ? 4'b1100 : 4'b0011;
                    wdata      = {2{store_data[15:0]}};
                    misaligned = addr_lo[0];
                end
                STORE_SW: begin
                    be         = 4'b1111;
                    wdata      = store_data;
                    misaligned = (addr_lo != 2'b00);
                end
                default: begin
                    be         = 4'b0000;
                    wdata      = 32'h0000_0000;
                    misaligned = 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage controller: accepts one load/store from EX/MEM, checks alignment,
// drives the data-memory req/ack handshake with a bounded wait, stalls the
// pipeline while outstanding and hands the raw read word to load-extract.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int MAX_WAIT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_valid,
    input  logic              ex_mem_read,
    input  logic              ex_mem_write,
    input  logic [ADDR_W-1:0] ex_addr,
    input  logic [2:0]        ex_load_type,
    input  logic [1:0]        ex_store_type,
    input  logic [31:0]       ex_store_data,
    output logic              stall,
    mem_access_unit_if.master mem,
    output logic              ld_valid,
    output logic [31:0]       ld_data,
    output logic [2:0]        ld_type,
    output logic [1:0]        ld_addr_lo,
    output logic              exc_align,
    output logic              exc_bus
);

    localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

    logic [0:0]        state_r;
    logic [7:0]        wait_cnt_r;
    logic              mem_req_r;
    logic              mem_we_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [3:0]        mem_be_r;
    logic [31:0]       mem_wdata_r;
    logic              ld_valid_r;
    logic [31:0]       ld_data_r;
    logic [2:0]        ld_type_r;
    logic [1:0]        ld_addr_lo_r;
    logic              exc_align_r;
    logic              exc_bus_r;

    logic              accept_s;
    logic              issue_s;
    logic              timeout_s;
    logic [3:0]        be_s;
    logic [31:0]       wdata_s;
    logic              misaligned_s;

    // A read wins over a simultaneous write, so the lane generator sees a read.
    mem_byte_lane_gen u_lane_gen (
        .addr_lo    (ex_addr[1:0]),
        .store_type (ex_store_type),
        .load_type  (ex_load_type),
        .is_read    (ex_mem_read),
        .store_data (ex_store_data),
        .be         (be_s),
        .wdata      (wdata_s),
        .misaligned (misaligned_s)
    );

    // Request qualification and wait-limit detection.
    always_comb begin
        accept_s  = (state_r == ST_IDLE) && ex_valid && (ex_mem_read || ex_mem_write);
        issue_s   = accept_s && !misaligned_s;
        timeout_s = (state_r == ST_REQ) && !mem.mem_ack && (wait_cnt_r == MAX_WAIT_C);
    end

    // Stall upstream from the accept cycle until the ack cycle.
    always_comb begin
        stall = 1'b0;
        case (state_r)
            ST_IDLE: stall = issue_s;
            ST_REQ:  stall = !mem.mem_ack;
            default: stall = 1'b0;
        endcase
    end

    // Access FSM, latched request fields, load return and exception pulses.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            wait_cnt_r   <= 8'd0;
            mem_req_r    <= 1'b0;
            mem_we_r     <= 1'b0;
            mem_addr_r   <= '0;
            mem_be_r     <= 4'b0000;
            mem_wdata_r  <= 32'h0000_0000;
            ld_valid_r   <= 1'b0;
            ld_data_r    <= 32'h0000_0000;
            ld_type_r    <= 3'd0;
            ld_addr_lo_r <= 2'b00;
            exc_align_r  <= 1'b0;
            exc_bus_r    <= 1'b0;
        end else begin
            ld_valid_r  <= 1'b0;
            exc_align_r <= 1'b0;
            exc_bus_r   <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (accept_s && misaligned_s) begin
                        exc_align_r <= 1'b1;
                    end else if (issue_s) begin
                        state_r      <= ST_REQ;
                        wait_cnt_r   <= 8'd0;
                        mem_req_r    <= 1'b1;
                        mem_we_r     <= !ex_mem_read;
                        mem_addr_r   <= {ex_addr[ADDR_W-1:2], 2'b00};
                        mem_be_r     <= be_s;
                        mem_wdata_r  <= wdata_s;
                        ld_type_r    <= ex_load_type;
                        ld_addr_lo_r <= ex_addr[1:0];
                    end
                end
                ST_REQ: begin
                    if (mem.mem_ack) begin
                        state_r   <= ST_IDLE;
                        mem_req_r <= 1'b0;
                        if (!mem_we_r) begin
                            ld_valid_r <= 1'b1;
                            ld_data_r  <= mem.mem_rdata;
                        end
                    end else if (timeout_s) begin
                        state_r   <= ST_IDLE;
                        mem_req_r <= 1'b0;
                        exc_bus_r <= 1'b1;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + 8'd1;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    mem_req_r <= 1'b0;
                end
            endcase
        end
    end

    assign mem.mem_req   = mem_req_r;
    assign mem.mem_we    = mem_we_r;
    assign mem.mem_addr  = mem_addr_r;
    assign mem.mem_be    = mem_be_r;
    assign mem.mem_wdata = mem_wdata_r;
    assign ld_valid      = ld_valid_r;
    assign ld_data       = ld_data_r;
    assign ld_type       = ld_type_r;
    assign ld_addr_lo    = ld_addr_lo_r;
    assign exc_align     = exc_align_r;
    assign exc_bus       = exc_bus_r;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed table, hand-written corner sequences
// (timeout, back-to-back, reset mid-access) and random requests checked
// against a size-based reference model.
module tb_mem_access_unit;
    import mem_pkg::*;

    localparam int MAX_WAIT = 15;

    logic        clk;
    logic        rst_n;
    logic        ex_valid;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic [31:0] ex_addr;
    logic [2:0]  ex_load_type;
    logic [1:0]  ex_store_type;
    logic [31:0] ex_store_data;
    logic        stall;
    logic        ld_valid;
    logic [31:0] ld_data;
    logic [2:0]  ld_type;
    logic [1:0]  ld_addr_lo;
    logic        exc_align;
    logic        exc_bus;

    int total = 0;
    int bad   = 0;

    mem_access_unit_if #(.ADDR_W(32)) mif ();

    mem_access_unit #(.ADDR_W(32), .MAX_WAIT(MAX_WAIT)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ex_valid      (ex_valid),
        .ex_mem_read   (ex_mem_read),
        .ex_mem_write  (ex_mem_write),
        .ex_addr       (ex_addr),
        .ex_load_type  (ex_load_type),
        .ex_store_type (ex_store_type),
        .ex_store_data (ex_store_data),
        .stall         (stall),
        .mem           (mif),
        .ld_valid      (ld_valid),
        .ld_data       (ld_data),
        .ld_type       (ld_type),
        .ld_addr_lo    (ld_addr_lo),
        .exc_align     (exc_align),
        .exc_bus       (exc_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct {
        logic        rd;
        logic        wr;
        logic [2:0]  lt;
        logic [1:0]  st;
        logic [31:0] addr;
        logic [31:0] sdata;
        int          dly;
        logic [31:0] rdata;
        logic        e_align;
        logic [3:0]  e_be;
        logic [31:0] e_wdata;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic rd, input logic wr, input logic [2:0] lt,
                                input logic [1:0] st, input logic [31:0] addr,
                                input logic [31:0] sdata, input int dly,
                                input logic [31:0] rdata, input logic ea,
                                input logic [3:0] ebe, input logic [31:0] ewd);
        vec_t v;
        v.rd = rd; v.wr = wr; v.lt = lt; v.st = st; v.addr = addr; v.sdata = sdata;
        v.dly = dly; v.rdata = rdata; v.e_align = ea; v.e_be = ebe; v.e_wdata = ewd;
        return v;
    endfunction

    // Reference model: access size in bytes decides alignment, lanes and replication.
    function automatic vec_t model(input logic rd, input logic wr, input logic [2:0] lt,
                                   input logic [1:0] st, input logic [31:0] addr,
                                   input logic [31:0] sdata, input int dly,
                                   input logic [31:0] rdata);
        vec_t v;
        int n;
        int lo;
        v = mk(rd, wr, lt, st, addr, sdata, dly, rdata, 1'b0, 4'h0, 32'h0);
        lo = int'(addr[1:0]);
        if (rd) begin
            if (lt <= 3'd1)      n = 1;
            else if (lt <= 3'd3) n = 2;
            else if (lt == 3'd4) n = 4;
            else                 n = 0;
            v.e_be    = 4'hF;
            v.e_wdata = 32'h0;
        end else begin
            n = (st == 2'd3) ? 0 : (1 << st);
            if (n != 0) begin
                v.e_be = 4'(((1 << n) - 1) << lo);
                for (int i = 0; i < 4; i++)
                    v.e_wdata[8*i +: 8] = sdata[8*(i % n) +: 8];
            end
        end
        v.e_align = (n == 0) || ((lo % ((n == 0) ? 1 : n)) != 0);
        return v;
    endfunction

    task automatic chk_bus(input string tag, input vec_t v);
        chk({tag, "_req"},   32'(mif.mem_req), 32'd1);
        chk({tag, "_we"},    32'(mif.mem_we), 32'(!v.rd));
        chk({tag, "_addr"},  mif.mem_addr, v.addr & 32'hFFFF_FFFC);
        chk({tag, "_be"},    32'(mif.mem_be), 32'(v.e_be));
        chk({tag, "_wdata"}, mif.mem_wdata, v.e_wdata);
    endtask

    // Entered shortly after a negedge; returns shortly after a negedge.
    task automatic run_txn(input vec_t v);
        int stall_cycles;
        stall_cycles  = 0;
        ex_valid      = 1'b1;
        ex_mem_read   = v.rd;
        ex_mem_write  = v.wr;
        ex_addr       = v.addr;
        ex_load_type  = v.lt;
        ex_store_type = v.st;
        ex_store_data = v.sdata;
        #1;
        chk("accept_stall", 32'(stall), 32'(!v.e_align));
        if (stall) stall_cycles++;
        if (v.e_align) begin
            @(negedge clk);
            ex_valid = 1'b0;
            #1;
            chk("align_exc",   32'(exc_align), 32'd1);
            chk("align_noreq", 32'(mif.mem_req), 32'd0);
            chk("align_stall", 32'(stall), 32'd0);
        end else begin
            @(negedge clk);
            // a competing request during REQ must not disturb the access
            ex_mem_read   = 1'b1;
            ex_load_type  = LOAD_LW;
            ex_addr       = $urandom & 32'hFFFF_FFFC;
            ex_store_data = $urandom;
            for (int i = 0; i < v.dly; i++) begin
                #1;
                chk_bus("wait", v);
                chk("wait_stall", 32'(stall), 32'd1);
                if (stall) stall_cycles++;
                @(negedge clk);
            end
            mif.mem_ack   = 1'b1;
            mif.mem_rdata = v.rdata;
            #1;
            chk_bus("ack", v);
            chk("ack_stall", 32'(stall), 32'd0);
            if (stall) stall_cycles++;
            @(negedge clk);
            mif.mem_ack   = 1'b0;
            mif.mem_rdata = $urandom;
            ex_valid      = 1'b0;
            #1;
            chk("done_req",    32'(mif.mem_req), 32'd0);
            chk("done_ldv",    32'(ld_valid), 32'(v.rd));
            chk("done_excbus", 32'(exc_bus), 32'd0);
            chk("stall_cycles", 32'(stall_cycles), 32'(1 + v.dly));
            if (v.rd) begin
                chk("ld_data", ld_data, v.rdata);
                chk("ld_type", 32'(ld_type), 32'(v.lt));
                chk("ld_addr_lo", 32'(ld_addr_lo), 32'(v.addr[1:0]));
            end
        end
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        #1;
        chk("idle_ldv",   32'(ld_valid), 32'd0);
        chk("idle_exca",  32'(exc_align), 32'd0);
        chk("idle_excb",  32'(exc_bus), 32'd0);
        chk("idle_req",   32'(mif.mem_req), 32'd0);
    endtask

    task automatic run_timeout(input logic [31:0] addr);
        int  req_cycles;
        bit  done;
        req_cycles   = 0;
        done         = 1'b0;
        ex_valid     = 1'b1;
        ex_mem_read  = 1'b1;
        ex_mem_write = 1'b0;
        ex_load_type = LOAD_LW;
        ex_addr      = addr;
        #1;
        chk("to_accept_stall", 32'(stall), 32'd1);
        @(negedge clk);
        ex_valid = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            #1;
            if (mif.mem_req) begin
                req_cycles++;
                chk("to_wait_stall", 32'(stall), 32'd1);
                chk("to_wait_excb", 32'(exc_bus), 32'd0);
                @(negedge clk);
            end else begin
                done = 1'b1;
                chk("to_excbus", 32'(exc_bus), 32'd1);
                chk("to_stall", 32'(stall), 32'd0);
                chk("to_ldv", 32'(ld_valid), 32'd0);
            end
        end
        chk("to_finished", 32'(done), 32'd1);
        chk("to_req_cycles", 32'(req_cycles), 32'(MAX_WAIT + 1));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_req"},    32'(mif.mem_req), 32'd0);
        chk({tag, "_we"},     32'(mif.mem_we), 32'd0);
        chk({tag, "_addr"},   mif.mem_addr, 32'd0);
        chk({tag, "_be"},     32'(mif.mem_be), 32'd0);
        chk({tag, "_wdata"},  mif.mem_wdata, 32'd0);
        chk({tag, "_stall"},  32'(stall), 32'd0);
        chk({tag, "_ldv"},    32'(ld_valid), 32'd0);
        chk({tag, "_ldd"},    ld_data, 32'd0);
        chk({tag, "_ldt"},    32'(ld_type), 32'd0);
        chk({tag, "_ldlo"},   32'(ld_addr_lo), 32'd0);
        chk({tag, "_exca"},   32'(exc_align), 32'd0);
        chk({tag, "_excb"},   32'(exc_bus), 32'd0);
    endtask

    vec_t tbl[15];

    initial begin
        vec_t v;
        logic rd;
        logic wr;
        int   kind;

        rst_n = 1'b0; ex_valid = 1'b0; ex_mem_read = 1'b0; ex_mem_write = 1'b0;
        ex_addr = 32'h0; ex_load_type = 3'd0; ex_store_type = 2'd0; ex_store_data = 32'h0;
        mif.mem_ack = 1'b0; mif.mem_rdata = 32'h0;

        //        rd    wr    lt        st        addr          sdata         dly rdata         ea    be       wdata
        tbl[0]  = mk(1'b0, 1'b1, 3'd0,    STORE_SB, 32'h0000_1003, 32'h0000_00A5, 2,  32'h0,        1'b0, 4'b1000, 32'hA5A5_A5A5);
        tbl[1]  = mk(1'b1, 1'b0, LOAD_LH, 2'd0,     32'h0000_2002, 32'h0,         1,  32'h8001_7FFF, 1'b0, 4'b1111, 32'h0);
        tbl[2]  = mk(1'b1, 1'b0, LOAD_LW, 2'd0,     32'h0000_3001, 32'h0,         0,  32'h0,        1'b1, 4'b0000, 32'h0);
        tbl[3]  = mk(1'b0, 1'b1, 3'd0,    STORE_SH, 32'h0000_4002, 32'h1234_BEEF, 0,  32'h0,        1'b0, 4'b1100, 32'hBEEF_BEEF);
        tbl[4]  = mk(1'b0, 1'b1, 3'd0,    STORE_SH, 32'h0000_4001, 32'h1234_BEEF, 0,  32'h0,        1'b1, 4'b0000, 32'h0);
        tbl[5]  = mk(1'b0, 1'b1, 3'd0,    STORE_SW, 32'h0000_5000, 32'hDEAD_BEEF, 3,  32'h0,        1'b0, 4'b1111, 32'hDEAD_BEEF);
        tbl[6]  = mk(1'b1, 1'b0, LOAD_LBU,2'd0,     32'h0000_6001, 32'h0,         0,  32'h1122_3344, 1'b0, 4'b1111, 32'h0);
        tbl[7]  = mk(1'b1, 1'b1, LOAD_LW, STORE_SB, 32'h0000_7000, 32'hFFFF_FFFF, 2,  32'hCAFE_F00D, 1'b0, 4'b1111, 32'h0);
        tbl[8]  = mk(1'b1, 1'b0, 3'd5,    2'd0,     32'h0000_8000, 32'h0,         0,  32'h0,        1'b1, 4'b0000, 32'h0);
        tbl[9]  = mk(1'b0, 1'b1, 3'd0,    2'd3,     32'h0000_8000, 32'h0,         0,  32'h0,        1'b1, 4'b0000, 32'h0);
        tbl[10] = mk(1'b0, 1'b1, 3'd0,    STORE_SB, 32'h0000_9000, 32'h0000_005A, 0,  32'h0,        1'b0, 4'b0001, 32'h5A5A_5A5A);
        tbl[11] = mk(1'b1, 1'b0, LOAD_LHU,2'd0,     32'h0000_A003, 32'h0,         0,  32'h0,        1'b1, 4'b0000, 32'h0);
        tbl[12] = mk(1'b1, 1'b0, LOAD_LW, 2'd0,     32'h0000_B000, 32'h0,         MAX_WAIT, 32'h0F0F_1234, 1'b0, 4'b1111, 32'h0);
        tbl[13] = mk(1'b0, 1'b1, 3'd0,    STORE_SH, 32'h0000_C000, 32'hFFFF_8001, 1,  32'h0,        1'b0, 4'b0011, 32'h8001_8001);
        tbl[14] = mk(1'b1, 1'b0, LOAD_LB, 2'd0,     32'h0000_D002, 32'h0,         0,  32'h7F7F_7F7F, 1'b0, 4'b1111, 32'h0);

        // reset state
        repeat (3) @(negedge clk);
        #1;
        chk_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // mem_ack while idle is ignored
        mif.mem_ack   = 1'b1;
        mif.mem_rdata = 32'h1357_9BDF;
        @(negedge clk);
        mif.mem_ack = 1'b0;
        #1;
        chk("idle_ack_ldv", 32'(ld_valid), 32'd0);
        chk("idle_ack_ldd", ld_data, 32'd0);
        chk("idle_ack_req", 32'(mif.mem_req), 32'd0);

        // ex_valid with neither read nor write is not a request
        ex_valid = 1'b1; ex_mem_read = 1'b0; ex_mem_write = 1'b0;
        ex_addr = 32'h0000_3001; ex_load_type = LOAD_LW;
        #1;
        chk("nop_stall", 32'(stall), 32'd0);
        @(negedge clk);
        ex_valid = 1'b0;
        #1;
        chk("nop_req", 32'(mif.mem_req), 32'd0);
        chk("nop_exca", 32'(exc_align), 32'd0);

        // directed table
        foreach (tbl[i]) begin
            run_txn(tbl[i]);
            idle_cycle();
        end

        // timeout, then a normal load is accepted
        run_timeout(32'h0000_E000);
        idle_cycle();
        run_txn(mk(1'b1, 1'b0, LOAD_LW, 2'd0, 32'h0000_E004, 32'h0, 0, 32'h2468_ACE0, 1'b0, 4'b1111, 32'h0));
        idle_cycle();

        // back-to-back SW then LW, each acked immediately
        run_txn(mk(1'b0, 1'b1, 3'd0, STORE_SW, 32'h0000_F000, 32'h0BAD_CAFE, 0, 32'h0, 1'b0, 4'b1111, 32'h0BAD_CAFE));
        run_txn(mk(1'b1, 1'b0, LOAD_LW, 2'd0, 32'h0000_F004, 32'h0, 0, 32'h5555_AAAA, 1'b0, 4'b1111, 32'h0));
        idle_cycle();

        // reset in the middle of an LBU access, then a late ack
        ex_valid = 1'b1; ex_mem_read = 1'b1; ex_mem_write = 1'b0;
        ex_load_type = LOAD_LBU; ex_addr = 32'h0000_6003;
        @(negedge clk);
        ex_valid = 1'b0;
        #1;
        chk("rstmid_req_up", 32'(mif.mem_req), 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        chk_all_zero("rstmid");
        rst_n         = 1'b1;
        mif.mem_ack   = 1'b1;
        mif.mem_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        mif.mem_ack = 1'b0;
        #1;
        chk("late_ack_ldv", 32'(ld_valid), 32'd0);
        chk("late_ack_ldd", ld_data, 32'd0);
        chk("late_ack_req", 32'(mif.mem_req), 32'd0);
        chk("late_ack_excb", 32'(exc_bus), 32'd0);
        idle_cycle();

        // randomized requests against the reference model
        for (int n = 0; n < 40; n++) begin
            kind = $urandom_range(0, 2);
            rd   = (kind != 1);
            wr   = (kind != 0);
            v = model(rd, wr, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
                      $urandom, $urandom, $urandom_range(0, 4), $urandom);
            run_txn(v);
            if ($urandom_range(0, 1) == 1) idle_cycle();
        end
        idle_cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
